// File: rtl/fetch_ctrl_pkg.sv
// Shared core types for the IF stage.
// Holds the fetch FSM encoding and fetch constants.
package core_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        FULL,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bus: imem request/response plus IF/ID handshake.
// master = fetch controller, slave = memory and ID side.
interface fetch_ctrl_if #(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 32
);

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               id_valid;
    logic               id_ready;
    logic [PC_W-1:0]    id_pc;
    logic [INSTR_W-1:0] id_instr;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_instr
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_instr
    );

endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: single-outstanding imem fetch,
// IF/ID buffer with valid/ready, EX redirects with stale drop.
module fetch_ctrl
    import core_pkg::*;
#(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_cur,
    output logic [PC_W-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    fetch_ctrl_if.master    bus
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic               id_valid_q;
    logic [PC_W-1:0]    id_pc_q;
    logic [INSTR_W-1:0] id_instr_q;

    logic            req;
    logic            capture;
    logic            drop;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;

    assign target = {redirect_pc[PC_W-1:2], 2'b00};
    assign pc_inc = pc_cur + PC_W'(PC_INC);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request strobe and PC selection
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        capture = 1'b0;
        drop    = 1'b0;
        pc_d    = pc_cur;
        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d = target;
                end else begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = target;
                    state_d = bus.imem_rvalid ? REQ : DRAIN;
                end else if (bus.imem_rvalid) begin
                    capture = 1'b1;
                    pc_d    = pc_inc;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (redirect_valid) begin
                    drop    = 1'b1;
                    pc_d    = target;
                    state_d = REQ;
                end else if (bus.id_ready) begin
                    req     = 1'b1;
                    drop    = 1'b1;
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                // the in-flight response retires the slot even if
                // a new redirect lands in the same cycle
                if (redirect_valid) begin
                    pc_d = target;
                end
                if (bus.imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // IF/ID buffer: capture on response, clear on hand-off/flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
        end else if (capture) begin
            id_valid_q <= 1'b1;
            id_pc_q    <= pc_cur;
            id_instr_q <= bus.imem_rdata;
        end else if (drop) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
        end
    end

    assign bus.imem_req  = req & ~rst;
    assign bus.imem_addr = pc_cur;
    assign pc_next       = rst ? pc_cur : pc_d;

    assign bus.id_valid = id_valid_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_instr = id_valid_q ? id_instr_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register and
// a variable-latency single-slot instruction memory model.
module tb_fetch_ctrl;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] pc_cur;
    logic [PC_W-1:0] pc_next;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;

    fetch_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;

    logic            pend = 1'b0;
    int              cnt  = 0;
    logic [PC_W-1:0] maddr = '0;

    fetch_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [PC_W-1:0] a);
        return {16'hC0DE, 10'h0, a};
    endfunction

    // PC register: loads every clock, clears on reset
    always @(posedge clk or posedge rst) begin
        if (rst) pc_cur <= '0;
        else     pc_cur <= pc_next;
    end

    // single-slot memory: response lat cycles after request
    always @(posedge clk) begin
        bus.imem_rvalid <= 1'b0;
        if (pend && cnt == 1) begin
            bus.imem_rvalid <= 1'b1;
            bus.imem_rdata  <= mem_word(maddr);
            pend <= 1'b0;
        end else if (pend) begin
            cnt <= cnt - 1;
        end
        if (bus.imem_req) begin
            pend  <= 1'b1;
            cnt   <= lat;
            maddr <= bus.imem_addr;
        end
    end

    task automatic check(string tag, logic [31:0] obs,
                         logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        do begin
            step();
            k++;
        end while (!bus.id_valid && k < max);
        check("wait_valid", 32'(bus.id_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int  k;
        logic saw;
        bus.id_ready    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        repeat (3) step();
        check("rst_valid", 32'(bus.id_valid), 0);
        check("rst_pc", 32'(bus.id_pc), 0);
        check("rst_instr", bus.id_instr, 32'h13);
        check("rst_req", 32'(bus.imem_req), 0);
        check("rst_pcn", 32'(pc_next), 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_req", 32'(bus.imem_req), 1);
        check("first_addr", 32'(bus.imem_addr), 0);

        for (int i = 0; i < 3; i++) begin
            wait_valid(4);
            check("seq_pc", 32'(bus.id_pc), 32'(i * 4));
            check("seq_instr", bus.id_instr,
                  mem_word(PC_W'(i * 4)));
            if (i < 2) begin
                check("seq_addr", 32'(bus.imem_addr),
                      32'(i * 4 + 4));
            end else begin
                bus.id_ready = 1'b0;
                #1;
                check("stall_req", 32'(bus.imem_req), 0);
                check("stall_pcn", 32'(pc_next), 32'h0C);
            end
        end

        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 32'(bus.id_valid), 1);
            check("hold_pc", 32'(bus.id_pc), 32'h08);
            check("hold_instr", bus.id_instr, mem_word(6'h08));
            check("hold_req", 32'(bus.imem_req), 0);
            check("hold_pcn", 32'(pc_next), 32'h0C);
        end
        bus.id_ready = 1'b1;
        #1;
        check("rel_req", 32'(bus.imem_req), 1);
        check("rel_addr", 32'(bus.imem_addr), 32'h0C);

        for (int p = 12; p <= 60; p += 4) begin
            wait_valid(4);
            check("run_pc", 32'(bus.id_pc), 32'(p));
        end
        check("wrap_req", 32'(bus.imem_req), 1);
        check("wrap_addr", 32'(bus.imem_addr), 0);

        lat = 3;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 6'h23;
        #1;
        check("rd_pcn", 32'(pc_next), 32'h20);
        step();
        redirect_valid = 1'b0;
        #1;
        check("drain_req", 32'(bus.imem_req), 0);
        check("drain_pcn", 32'(pc_next), 32'h20);
        k   = 0;
        saw = 1'b0;
        do begin
            step();
            k++;
            if (bus.id_valid) saw = 1'b1;
        end while (!bus.imem_req && k < 8);
        check("drain_novalid", 32'(saw), 0);
        check("drain_next_req", 32'(bus.imem_req), 1);
        check("drain_next_addr", 32'(bus.imem_addr), 32'h20);

        k = 0;
        do begin
            step();
            k++;
        end while (!bus.imem_rvalid && k < 8);
        check("same_rvalid", 32'(bus.imem_rvalid), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 6'h11;
        #1;
        check("same_pcn", 32'(pc_next), 32'h10);
        step();
        redirect_valid = 1'b0;
        lat = 1;
        #1;
        check("same_valid", 32'(bus.id_valid), 0);
        check("same_req", 32'(bus.imem_req), 1);
        check("same_addr", 32'(bus.imem_addr), 32'h10);

        wait_valid(4);
        check("full_pc", 32'(bus.id_pc), 32'h10);
        check("full_instr", bus.id_instr, mem_word(6'h10));
        bus.id_ready   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 6'h30;
        #1;
        check("flush_pcn", 32'(pc_next), 32'h30);
        check("flush_noreq", 32'(bus.imem_req), 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("flush_valid", 32'(bus.id_valid), 0);
        check("flush_instr", bus.id_instr, 32'h13);
        check("flush_pc", 32'(bus.id_pc), 32'h10);
        check("flush_req", 32'(bus.imem_req), 1);
        check("flush_addr", 32'(bus.imem_addr), 32'h30);
        bus.id_ready = 1'b1;
        lat = 3;

        step();
        rst = 1'b1;
        #1;
        check("mrst_valid", 32'(bus.id_valid), 0);
        check("mrst_req", 32'(bus.imem_req), 0);
        check("mrst_pcn", 32'(pc_next), 0);
        step();
        rst = 1'b0;
        #1;
        check("mrst_req2", 32'(bus.imem_req), 1);
        check("mrst_addr", 32'(bus.imem_addr), 0);
        wait_valid(8);
        check("mrst_pc", 32'(bus.id_pc), 0);
        check("mrst_instr", bus.id_instr, mem_word(6'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
